// File: rtl/hack_fb_pkg.sv
// Shared geometry defaults and address-width helper for the Hack frame buffer.
package hack_fb_pkg;

   localparam int unsigned DEF_VGA_W    = 800;
   localparam int unsigned DEF_VGA_H    = 480;
   localparam int unsigned DEF_SCREEN_W = 512;
   localparam int unsigned DEF_SCREEN_H = 256;
   localparam int unsigned DEF_WORD_W   = 16;
   localparam int unsigned DEF_H_OFFSET = 144;
   localparam int unsigned DEF_V_OFFSET = 112;

   localparam int unsigned COORD_W = 11;
   localparam int unsigned DIFF_W  = 12;

   // Word-address width needed to hold a whole screen of packed pixels.
   function automatic int unsigned fb_addr_w(input int unsigned screen_w,
                                             input int unsigned screen_h,
                                             input int unsigned word_w);
      return $clog2((screen_w * screen_h) / word_w);
   endfunction

endpackage

// File: rtl/hack_frame_buffer_dpram.sv
// fb_dpram: simple dual-port RAM, one write port, one registered read port, read-before-write.
module fb_dpram
   import hack_fb_pkg::*;
#(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   (* ramstyle = "M9K" *) logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q;

   // Non-blocking update means a same-address read sees the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/hack_frame_buffer.sv
// Hack screen frame buffer feeding a VGA pixel stream with two-cycle latency.
// Define HACK_FB_DOUBLE_BUFFER_EN for two banks with frame-aligned swaps.
module hack_frame_buffer
   import hack_fb_pkg::*;
#(
   parameter int unsigned WORD_W   = DEF_WORD_W,
   parameter int unsigned SCREEN_W = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H = DEF_SCREEN_H,
   parameter int unsigned H_OFFSET = DEF_H_OFFSET,
   parameter int unsigned V_OFFSET = DEF_V_OFFSET,
   parameter logic        BORDER   = 1'b0,
   localparam int unsigned ADDR_W  = fb_addr_w(SCREEN_W, SCREEN_H, WORD_W)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [ADDR_W-1:0]  write_address,
   input  logic [WORD_W-1:0]  data_in,
   input  logic               load,
   input  logic [COORD_W-1:0] vga_h,
   input  logic [COORD_W-1:0] vga_v,
   input  logic               vga_de,
   input  logic               frame_start,
   input  logic               swap_req,
   output logic               pixel_out,
   output logic               pixel_de,
   output logic               front_bank
);

   localparam int unsigned X_W   = $clog2(SCREEN_W);
   localparam int unsigned Y_W   = $clog2(SCREEN_H);
   localparam int unsigned BIT_W = $clog2(WORD_W);
`ifdef HACK_FB_DOUBLE_BUFFER_EN
   localparam int unsigned RAM_AW = ADDR_W + 1;
`else
   localparam int unsigned RAM_AW = ADDR_W;
`endif

   logic [DIFF_W-1:0] x_c;
   logic [DIFF_W-1:0] y_c;
   logic              in_win_c;
   logic [ADDR_W-1:0] rd_word_addr_c;
   logic [RAM_AW-1:0] ram_rd_addr_c;
   logic [RAM_AW-1:0] ram_wr_addr_c;
   logic [WORD_W-1:0] rd_word;

   logic              in_win_q, in_win_d;
   logic              de_q, de_d;
   logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
   logic              pixel_q, pixel_d;
   logic              pixel_de_q, pixel_de_d;

   // Window test and address generation; a wrapped difference lands out of range.
   always_comb begin
      x_c            = DIFF_W'(vga_h) - DIFF_W'(H_OFFSET);
      y_c            = DIFF_W'(vga_v) - DIFF_W'(V_OFFSET);
      in_win_c       = (x_c < DIFF_W'(SCREEN_W)) && (y_c < DIFF_W'(SCREEN_H));
      rd_word_addr_c = '0;
      if (in_win_c) begin
         rd_word_addr_c = {y_c[Y_W-1:0], x_c[X_W-1:BIT_W]};
      end
   end

`ifdef HACK_FB_DOUBLE_BUFFER_EN
   logic front_bank_q, front_bank_d;
   logic swap_pending_q, swap_pending_d;

   // Swaps only take effect on frame_start; extra requests collapse into one.
   always_comb begin
      front_bank_d   = front_bank_q;
      swap_pending_d = swap_pending_q;
      if (frame_start && (swap_pending_q || swap_req)) begin
         front_bank_d   = ~front_bank_q;
         swap_pending_d = 1'b0;
      end else if (swap_req) begin
         swap_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         front_bank_q   <= 1'b0;
         swap_pending_q <= 1'b0;
      end else begin
         front_bank_q   <= front_bank_d;
         swap_pending_q <= swap_pending_d;
      end
   end

   assign ram_rd_addr_c = {front_bank_q, rd_word_addr_c};
   assign ram_wr_addr_c = {~front_bank_q, write_address};
   assign front_bank    = front_bank_q;
`else
   logic unused_swap_c;

   assign unused_swap_c = &{1'b0, frame_start, swap_req};
   assign ram_rd_addr_c = rd_word_addr_c;
   assign ram_wr_addr_c = write_address;
   assign front_bank    = 1'b0;
`endif

   fb_dpram #(
      .ADDR_W (RAM_AW),
      .DATA_W (WORD_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (load),
      .wr_addr (ram_wr_addr_c),
      .wr_data (data_in),
      .rd_addr (ram_rd_addr_c),
      .rd_data (rd_word)
   );

   // S1 carries window/enable/bit index alongside the RAM read; S2 selects the pixel.
   always_comb begin
      in_win_d   = in_win_c;
      de_d       = vga_de;
      bit_idx_d  = x_c[BIT_W-1:0];
      pixel_de_d = de_q;
      pixel_d    = 1'b0;
      if (de_q) begin
         pixel_d = in_win_q ? rd_word[bit_idx_q] : BORDER;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         in_win_q   <= 1'b0;
         de_q       <= 1'b0;
         bit_idx_q  <= '0;
         pixel_q    <= 1'b0;
         pixel_de_q <= 1'b0;
      end else begin
         in_win_q   <= in_win_d;
         de_q       <= de_d;
         bit_idx_q  <= bit_idx_d;
         pixel_q    <= pixel_d;
         pixel_de_q <= pixel_de_d;
      end
   end

   assign pixel_out = pixel_q;
   assign pixel_de  = pixel_de_q;

endmodule

// File: tb/tb_hack_frame_buffer.sv
// Directed-vector bench for hack_frame_buffer with a shadow-memory pixel model.
module tb_hack_frame_buffer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [12:0] write_address;
   logic [15:0] data_in;
   logic        load;
   logic [10:0] vga_h;
   logic [10:0] vga_v;
   logic        vga_de;
   logic        frame_start;
   logic        swap_req;
   logic        pixel_out;
   logic        pixel_de;
   logic        front_bank;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] shadow [8192];
   logic        exp_px_q [$];
   logic        exp_de_q [$];

   hack_frame_buffer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .write_address (write_address),
      .data_in       (data_in),
      .load          (load),
      .vga_h         (vga_h),
      .vga_v         (vga_v),
      .vga_de        (vga_de),
      .frame_start   (frame_start),
      .swap_req      (swap_req),
      .pixel_out     (pixel_out),
      .pixel_de      (pixel_de),
      .front_bank    (front_bank)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input int a, input logic [15:0] d);
      write_address = 13'(a);
      data_in       = d;
      load          = 1'b1;
      step();
      load          = 1'b0;
      shadow[a]     = d;
   endtask

   task automatic rd(input int h, input int v, input logic de, output logic px, output logic pde);
      vga_h  = 11'(h);
      vga_v  = 11'(v);
      vga_de = de;
      step();
      step();
      px  = pixel_out;
      pde = pixel_de;
   endtask

   function automatic logic model_px(input int h, input int v, input logic de);
      int x, y;
      logic [15:0] w;
      if (!de) return 1'b0;
      x = h - 144;
      y = v - 112;
      if (x < 0 || x >= 512 || y < 0 || y >= 256) return 1'b0;
      w = shadow[y * 32 + x / 16];
      return w[x % 16];
   endfunction

   // One streamed pixel: check the one issued two cycles ago, then issue this one.
   task automatic stream_px(input int h, input int v, input logic de);
      if (exp_px_q.size() == 2) begin
         check_eq("sweep_px", 32'(pixel_out), 32'(exp_px_q.pop_front()));
         check_eq("sweep_de", 32'(pixel_de), 32'(exp_de_q.pop_front()));
      end
      vga_h  = 11'(h);
      vga_v  = 11'(v);
      vga_de = de;
      exp_px_q.push_back(model_px(h, v, de));
      exp_de_q.push_back(de);
      step();
   endtask

   initial begin
      logic px, pde;
      int   rows [9] = '{0, 111, 112, 113, 250, 366, 367, 368, 479};

      reset_n = 1'b0; write_address = '0; data_in = '0; load = 1'b0;
      vga_h = '0; vga_v = '0; vga_de = 1'b0; frame_start = 1'b0; swap_req = 1'b0;
      @(negedge clk);
      repeat (3) step();
      check_eq("rst_pixel", 32'(pixel_out), 32'd0);
      check_eq("rst_de", 32'(pixel_de), 32'd0);
      check_eq("rst_bank", 32'(front_bank), 32'd0);
      reset_n = 1'b1;
      step();

`ifndef HACK_FB_DOUBLE_BUFFER_EN
      wr(0, 16'h0001);
      rd(144, 112, 1'b1, px, pde);
      check_eq("origin_px", 32'(px), 32'd1);
      check_eq("origin_de", 32'(pde), 32'd1);
      rd(145, 112, 1'b1, px, pde);
      check_eq("origin_next", 32'(px), 32'd0);

      wr(8191, 16'h8000);
      rd(655, 367, 1'b1, px, pde);
      check_eq("last_px", 32'(px), 32'd1);
      rd(656, 367, 1'b1, px, pde);
      check_eq("right_border", 32'(px), 32'd0);
      rd(143, 112, 1'b1, px, pde);
      check_eq("left_border", 32'(px), 32'd0);
      rd(144, 112, 1'b0, px, pde);
      check_eq("de_low_px", 32'(px), 32'd0);
      check_eq("de_low_de", 32'(pde), 32'd0);

      // Same-cycle write and read of address 5 returns the old word first.
      wr(5, 16'h0000);
      vga_h = 11'(224); vga_v = 11'(112); vga_de = 1'b1;
      write_address = 13'(5); data_in = 16'hFFFF; load = 1'b1;
      step();
      load = 1'b0;
      step();
      check_eq("collide_old", 32'(pixel_out), 32'd0);
      step();
      check_eq("collide_new", 32'(pixel_out), 32'd1);
      shadow[5] = 16'hFFFF;

      // Reset mid-line while the origin pixel is lit.
      rd(144, 112, 1'b1, px, pde);
      check_eq("pre_rst_px", 32'(px), 32'd1);
      reset_n = 1'b0;
      step();
      check_eq("midrst_px", 32'(pixel_out), 32'd0);
      check_eq("midrst_de", 32'(pixel_de), 32'd0);
      check_eq("midrst_bank", 32'(front_bank), 32'd0);
      step();
      reset_n = 1'b1;
      step();
      check_eq("post_rst_px", 32'(pixel_out), 32'd0);
      check_eq("post_rst_de", 32'(pixel_de), 32'd0);
      step();
      check_eq("ram_kept_px", 32'(pixel_out), 32'd1);
      check_eq("ram_kept_de", 32'(pixel_de), 32'd1);

      // Checkerboard fill then streamed rows around window edges and blanking.
      for (int a = 0; a < 8192; a++) begin
         wr(a, ((a / 32) % 2 == 1) ? 16'h5555 : 16'hAAAA);
      end
      for (int r = 0; r < 9; r++) begin
         for (int h = 0; h < 850; h++) begin
            stream_px(h, rows[r], 1'(h < 800));
         end
      end
      stream_px(0, 490, 1'b0);
      stream_px(0, 490, 1'b0);
`else
      // Bring bank 0 address 0 to a known zero via a swap round trip.
      frame_start = 1'b1; swap_req = 1'b1;
      step();
      frame_start = 1'b0; swap_req = 1'b0;
      check_eq("db_swap1", 32'(front_bank), 32'd1);
      wr(0, 16'h0000);
      frame_start = 1'b1; swap_req = 1'b1;
      step();
      frame_start = 1'b0; swap_req = 1'b0;
      check_eq("db_swap0", 32'(front_bank), 32'd0);

      wr(0, 16'hFFFF);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      check_eq("db_midframe_bank", 32'(front_bank), 32'd0);
      rd(144, 112, 1'b1, px, pde);
      check_eq("db_front_px", 32'(px), 32'd0);
      check_eq("db_front_de", 32'(pde), 32'd1);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check_eq("db_after_fs", 32'(front_bank), 32'd1);
      rd(144, 112, 1'b1, px, pde);
      check_eq("db_new_px", 32'(px), 32'd1);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check_eq("db_single_swap", 32'(front_bank), 32'd1);
      reset_n = 1'b0;
      step();
      check_eq("db_rst_bank", 32'(front_bank), 32'd0);
      check_eq("db_rst_px", 32'(pixel_out), 32'd0);
      reset_n = 1'b1;
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
